// File: rtl/ls_control_unit.sv
// Multi-cycle control unit for a small load/store core: fetch, decode, execute, writeback.
// Supports lw, sw, addi, add and sub; any other encoding halts the unit until reset.
module ls_control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        run,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic [31:0] instr_rdata,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] immediate,
  output logic        sub,
  output logic        I_type,
  output logic        R_type,
  output logic        WE_RF,
  output logic        WE_MEM,
  output logic        illegal
);

  // state     | meaning
  // FETCH     | request instruction at PC while run=1
  // DECODE    | instruction word arrives; latch if legal
  // EXECUTE   | datapath operates on the decoded fields
  // WRITEBACK | one-cycle write enable, PC += 4
  // HALT      | unsupported instruction seen; wait for reset
  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  // One-hot class {lw, sw, addi, add, sub}; all zero for anything unsupported.
  function automatic logic [4:0] classify(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    classify[4] = (opc == 7'b0000011) && (f3 == 3'b010);
    classify[3] = (opc == 7'b0100011) && (f3 == 3'b010);
    classify[2] = (opc == 7'b0010011) && (f3 == 3'b000);
    classify[1] = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
    classify[0] = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0100000);
  endfunction

  logic [4:0] rdata_cls;
  logic [4:0] ir_cls;
  logic       rdata_legal;

  assign rdata_cls   = classify(instr_rdata);
  assign ir_cls      = classify(ir_q);
  assign rdata_legal = |rdata_cls;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (run) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // IR only ever holds a legal word, so decoded outputs stay meaningful in HALT.
        if (rdata_legal) begin
          ir_d    = instr_rdata;
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        pc_d    = pc_q + 32'd4;
        state_d = ST_FETCH;
      end
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Decoded fields come straight from IR, which only changes on EXECUTE entry.
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign rd     = ir_q[11:7];
  assign I_type = ir_cls[4] | ir_cls[3] | ir_cls[2];
  assign R_type = ir_cls[1] | ir_cls[0];
  assign sub    = R_type & ir_q[30];

  always_comb begin
    immediate = 12'h000;
    if (ir_cls[3])                  immediate = {ir_q[31:25], ir_q[11:7]};
    else if (ir_cls[4] | ir_cls[2]) immediate = ir_q[31:20];
  end

  // Write enables decode the async-reset state register, so reset kills them at once.
  assign WE_RF   = (state_q == ST_WRITEBACK) & (ir_cls[4] | ir_cls[2] | ir_cls[1] | ir_cls[0]);
  assign WE_MEM  = (state_q == ST_WRITEBACK) & ir_cls[3];
  assign illegal = (state_q == ST_HALT);

  assign instr_addr = pc_q;
  assign instr_req  = RST_N & run & (state_q == ST_FETCH);

endmodule

// File: tb/tb_ls_control_unit.sv
// Directed bench for ls_control_unit: per-instruction stage checks, halt, reset and PC wrap.
module tb_ls_control_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        run;
  logic [31:0] instr_rdata;
  logic [31:0] cur_instr;

  logic [31:0] instr_addr;
  logic        instr_req;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] immediate;
  logic        sub, I_type, R_type, WE_RF, WE_MEM, illegal;

  logic [31:0] w_addr;
  logic        w_req;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [11:0] w_imm;
  logic        w_sub, w_it, w_rt, w_werf, w_wemem, w_ill;

  int n_checks = 0;
  int n_errors = 0;

  ls_control_unit u_dut (
    .CLK(CLK), .RST_N(RST_N), .run(run),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_rdata(instr_rdata),
    .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
    .sub(sub), .I_type(I_type), .R_type(R_type),
    .WE_RF(WE_RF), .WE_MEM(WE_MEM), .illegal(illegal)
  );

  ls_control_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .RST_N(RST_N), .run(run),
    .instr_addr(w_addr), .instr_req(w_req), .instr_rdata(instr_rdata),
    .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .immediate(w_imm),
    .sub(w_sub), .I_type(w_it), .R_type(w_rt),
    .WE_RF(w_werf), .WE_MEM(w_wemem), .illegal(w_ill)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: word valid one cycle after a request, garbage (an illegal jal) otherwise.
  always @(posedge CLK) instr_rdata <= instr_req ? cur_instr : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
  task automatic exec_instr(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [4:0] e_rd, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                            input logic [11:0] e_imm, input logic e_it, input logic e_rt,
                            input logic e_sub, input logic e_wrf, input logic e_wmem);
    cur_instr = ins;
    run = 1'b1;
    #1;
    check("fetch_req", instr_req, 1);
    check("fetch_addr", instr_addr, pc);
    @(negedge CLK);
    check("decode_req", instr_req, 0);
    check("decode_we", {WE_RF, WE_MEM}, 0);
    @(negedge CLK);
    check("exec_rd", rd, e_rd);
    check("exec_rs1", rs1, e_rs1);
    check("exec_rs2", rs2, e_rs2);
    check("exec_imm", immediate, e_imm);
    check("exec_itype", I_type, e_it);
    check("exec_rtype", R_type, e_rt);
    check("exec_sub", sub, e_sub);
    check("exec_we", {WE_RF, WE_MEM}, 0);
    @(negedge CLK);
    check("wb_we_rf", WE_RF, e_wrf);
    check("wb_we_mem", WE_MEM, e_wmem);
    check("wb_rd_stable", rd, e_rd);
    check("wb_illegal", illegal, 0);
    @(negedge CLK);
    check("next_addr", instr_addr, pc + 32'd4);
    check("next_we", {WE_RF, WE_MEM}, 0);
  endtask

  task automatic expect_illegal(input logic [31:0] ins, input logic [31:0] pc, input int n);
    cur_instr = ins;
    run = 1'b1;
    #1;
    check("ill_fetch_req", instr_req, 1);
    @(negedge CLK);
    check("ill_decode", illegal, 0);
    @(negedge CLK);
    for (int i = 0; i < n; i++) begin
      check("halt_illegal", illegal, 1);
      check("halt_req", instr_req, 0);
      check("halt_we", {WE_RF, WE_MEM}, 0);
      check("halt_pc", instr_addr, pc);
      @(negedge CLK);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    run   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b1;
    run = 1'b0;
    cur_instr = 32'h0;
    #1 RST_N = 1'b0;
    #2;
    check("rst_addr", instr_addr, 32'h0);
    check("rst_req", instr_req, 0);
    check("rst_we", {WE_RF, WE_MEM}, 0);
    check("rst_illegal", illegal, 0);
    check("rst_fields", {rd, rs1, rs2, immediate}, 0);
    check("rst_flags", {I_type, R_type, sub}, 0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_req", instr_req, 0);
      check("stall_addr", instr_addr, 32'h0);
    end

    check("wrap_start", w_addr, 32'hFFFF_FFFC);
    exec_instr(32'h01002083, 32'h00, 5'd1,  5'd0, 5'd16, 12'd16,  1, 0, 0, 1, 0);
    check("wrap_next", w_addr, 32'h0);
    exec_instr(32'h00102A23, 32'h04, 5'd20, 5'd0, 5'd1,  12'd20,  1, 0, 0, 0, 1);
    exec_instr(32'h00508533, 32'h08, 5'd10, 5'd1, 5'd5,  12'd0,   0, 1, 0, 1, 0);
    exec_instr(32'hFFF18013, 32'h0C, 5'd0,  5'd3, 5'd31, 12'hFFF, 1, 0, 0, 1, 0);
    exec_instr(32'h40B28A33, 32'h10, 5'd20, 5'd5, 5'd11, 12'd0,   0, 1, 1, 1, 0);

    // sw interrupted by reset in WRITEBACK
    cur_instr = 32'h00102A23;
    run = 1'b1;
    #1;
    check("sw_fetch_addr", instr_addr, 32'h14);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("sw_wb_we_mem", WE_MEM, 1);
    #2 RST_N = 1'b0;
    #1;
    check("rstwb_we_mem", WE_MEM, 0);
    check("rstwb_we_rf", WE_RF, 0);
    check("rstwb_addr", instr_addr, 32'h0);
    check("rstwb_req", instr_req, 0);
    check("rstwb_fields", {rd, rs2, immediate, I_type}, 0);
    run = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_rst_req", instr_req, 0);

    expect_illegal(32'hFFFF_FFFF, 32'h0, 20);
    do_reset();
    expect_illegal(32'h0000_0083, 32'h0, 3);
    do_reset();
    expect_illegal(32'h0220_8033, 32'h0, 3);
    do_reset();
    exec_instr(32'h00508533, 32'h00, 5'd10, 5'd1, 5'd5, 12'd0, 0, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ls_control_unit.md
LS_CONTROL_UNIT -- requirements
Module: ls_control_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port CLK, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port run, input, 1, meaning permission to fetch the next instruction.
REQ-005 The block SHALL have port instr_addr, output, 32, meaning the instruction memory byte address (equals PC).
REQ-006 The block SHALL have port instr_req, output, 1, meaning the instruction read request.
REQ-007 The block SHALL have port instr_rdata, input, 32, meaning the instruction word, valid exactly one cycle after instr_req.
REQ-008 The block SHALL have ports rs1, rs2 and rd, output, 5 each, meaning the register-file addresses for the datapath.
REQ-009 The block SHALL have port immediate, output, 12, meaning the I- or S-format immediate.
REQ-010 The block SHALL have ports sub, I_type and R_type, output, 1 each, meaning the datapath operation selects.
REQ-011 The block SHALL have ports WE_RF and WE_MEM, output, 1 each, meaning the register-file and data-memory write enables.
REQ-012 The block SHALL have port illegal, output, 1, meaning an unsupported instruction was decoded and the unit is halted.

Function
REQ-013 FSM states SHALL be FETCH, DECODE, EXECUTE, WRITEBACK and HALT; all other encodings SHALL go to FETCH.
REQ-014 In FETCH, the FSM SHALL assert instr_req=run; when run=1 it SHALL go to DECODE, otherwise it SHALL stay in FETCH.
REQ-015 In DECODE, the FSM SHALL latch instr_rdata into the IR and go to EXECUTE when the IR is legal, otherwise to HALT.
REQ-016 Legal instructions: lw (opcode 0000011, funct3 010), sw (0100011, 010), addi (0010011, 000), add (0110011, 000, funct7 0000000), sub (0110011, 000, funct7 0100000).
REQ-017 rs1, rs2 and rd SHALL be IR[19:15], IR[24:20] and IR[11:7] respectively, for every format.
REQ-018 immediate SHALL be IR[31:20] for lw/addi, {IR[31:25],IR[11:7]} for sw, and 0 for R-type.
REQ-019 I_type SHALL be 1 for lw/sw/addi; R_type SHALL be 1 for add/sub; sub SHALL be IR[30] for R-type and 0 otherwise.
REQ-020 Decoded outputs SHALL be registered and stable from EXECUTE entry until the next EXECUTE entry.
REQ-021 EXECUTE SHALL always go to WRITEBACK after exactly one cycle.
REQ-022 In WRITEBACK, the FSM SHALL pulse WE_RF=1 for lw/addi/add/sub and WE_MEM=1 for sw, for exactly one cycle; it SHALL also set PC<=PC+4 (mod 2^32 wrap) and go to FETCH.
REQ-023 WE_RF and WE_MEM SHALL never both be 1, and SHALL be 0 in every state except WRITEBACK.
REQ-024 Throughput SHALL be one instruction per 4 cycles with run held 1.
REQ-025 In HALT, illegal SHALL be 1, instr_req, WE_RF and WE_MEM SHALL be 0, PC SHALL hold, and the FSM SHALL leave HALT only on reset.
REQ-026 With rd=0, WE_RF SHALL still pulse; suppressing the x0 write is the register file's job.

Reset
REQ-027 RST_N=0 SHALL immediately, with no clock required, force state=FETCH, PC=RESET_PC, IR=0, all outputs 0 and illegal=0.
REQ-028 Reset asserted in any state, including mid-WRITEBACK, SHALL suppress any in-flight write enable within the same cycle.
REQ-029 After RST_N rises, the first instr_req SHALL occur in the first FETCH cycle in which run=1.

Verification
REQ-030 Scenario lw: instr 0x01002083 -> in EXECUTE rd=1, rs1=0, immediate=16, I_type=1; WE_RF pulses in WRITEBACK; next instr_addr=4.
REQ-031 Scenario sw: instr 0x00102A23 -> rs1=0, rs2=1, immediate=20, I_type=1; WE_MEM=1 for one cycle; WE_RF=0 throughout.
REQ-032 Scenario add then sub: 0x00508533 gives rd=10, rs1=1, rs2=5, R_type=1, sub=0; 0x40B28A33 gives rd=20, rs1=5, rs2=11, sub=1.
REQ-033 Scenario illegal: 0xFFFFFFFF -> illegal=1 from the cycle after DECODE; no write enables; PC frozen for 20 cycles despite run=1.
REQ-034 Scenario stall/reset: run=0 holds FETCH with instr_req=0; RST_N pulsed low during WRITEBACK of a sw -> WE_MEM drops at once, PC=RESET_PC.
REQ-035 Scenario wrap: with RESET_PC=32'hFFFF_FFFC, one legal instruction -> next instr_addr=0.
